// File: rtl/alien_bomb_dropper.sv
// alien_bomb_dropper: drops bombs from the alien formation toward the player ship.
// Holds up to NUM_BOMBS bombs, asks the alien controller for drop coordinates on a
// pseudo-random timer, moves bombs down on each frame tick, detects ship hits and
// paints bomb pixels for the VGA colour mux.
// Optional build macro: BOMB_LASER_COLLIDE_EN (player laser can destroy bombs).
module alien_bomb_dropper #(
  parameter int NUM_BOMBS     = 4,
  parameter int RADIUS        = 3,
  parameter int STEP_MOTION   = 2,
  parameter int FIRE_PERIOD   = 32,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SHIP_WIDTH    = 60,
  parameter int SHIP_HEIGHT   = 30,
  parameter int V_OFFSET      = 10,
  parameter logic [2:0] BACKGROUND = 3'd0,
  parameter logic [2:0] BOMB       = 3'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       dropAck,
  input  logic       dropNone,
  input  logic [9:0] dropX,
  input  logic [9:0] dropY,
  input  logic [9:0] gunPosition,
  input  logic [9:0] xLaser,
  input  logic [9:0] yLaser,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  output logic       dropReq,
  output logic       hitShip,
  output logic       killingBomb,
  output logic [2:0] bombsAlive,
  output logic [2:0] colorBomb
);

  localparam int SHIP_TOP = SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT;

  typedef enum logic [0:0] {COUNTING, REQUESTING} req_state_t;

  req_state_t           state_q, state_d;
  logic                 ack_taken;
  logic [9:0]           timer;
  logic [15:0]          lfsr;
  logic [NUM_BOMBS-1:0] alive;
  logic [9:0]           slot_x [NUM_BOMBS];
  logic [9:0]           slot_y [NUM_BOMBS];

  logic [NUM_BOMBS-1:0] load_sel;
  logic                 any_free;
  logic                 load_en;
  logic [NUM_BOMBS-1:0] ship_hit;
  logic [NUM_BOMBS-1:0] laser_hit;
  logic [NUM_BOMBS-1:0] bottom_exit;
  logic [NUM_BOMBS-1:0] in_disc;

  // Magnitude of the difference of two screen coordinates, free of wrap artefacts.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? 11'(-d) : 11'(d);
  endfunction

  // Squared distance along one axis.
  function automatic logic [21:0] sq_diff(input logic [9:0] a, input logic [9:0] b);
    logic [21:0] m;
    m = {11'b0, abs_diff(a, b)};
    return m * m;
  endfunction

  function automatic logic [2:0] count_live(input logic [NUM_BOMBS-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NUM_BOMBS; i++) c = c + 3'(v[i]);
    return c;
  endfunction

`ifndef BOMB_LASER_COLLIDE_EN
  logic unused_laser;
  assign unused_laser = ^{xLaser, yLaser};
`endif

  assign dropReq = (state_q == REQUESTING);
  assign any_free = |(~alive);
  assign load_en  = ack_taken && !dropNone && any_free;

  // Pick the lowest-index dead slot as the target of the next load.
  always_comb begin
    logic found;
    load_sel = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (!alive[i] && !found) begin
        load_sel[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Per-slot geometry: ship overlap, laser overlap, bottom exit and pixel coverage.
  always_comb begin
    ship_hit    = '0;
    laser_hit   = '0;
    bottom_exit = '0;
    in_disc     = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      ship_hit[i]    = (abs_diff(slot_x[i], gunPosition) <= 11'(SHIP_WIDTH / 2)) &&
                       (slot_y[i] >= 10'(SHIP_TOP));
      bottom_exit[i] = ({1'b0, slot_y[i]} + 11'(STEP_MOTION)) >= 11'(SCREEN_HEIGHT);
      in_disc[i]     = ({1'b0, sq_diff(hPos, slot_x[i])} + {1'b0, sq_diff(vPos, slot_y[i])})
                       <= 23'(RADIUS * RADIUS);
`ifdef BOMB_LASER_COLLIDE_EN
      laser_hit[i]   = (abs_diff(slot_x[i], xLaser) <= 11'(2 * RADIUS)) &&
                       (abs_diff(slot_y[i], yLaser) <= 11'(2 * RADIUS));
`endif
    end
  end

  // Request handshake: wait for the timer and a free slot, then hold until acked.
  always_comb begin
    state_d   = state_q;
    ack_taken = 1'b0;
    case (state_q)
      COUNTING: begin
        if (timer == 10'd0 && any_free) state_d = REQUESTING;
      end
      REQUESTING: begin
        if (dropAck) begin
          ack_taken = 1'b1;
          state_d   = COUNTING;
        end
      end
      default: state_d = COUNTING;
    endcase
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= COUNTING;
    else       state_q <= state_d;
  end

  // Drop timer and LFSR jitter source.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= 10'(FIRE_PERIOD);
      lfsr  <= 16'hACE1;
    end else begin
      if (enable) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (ack_taken)
        timer <= 10'(FIRE_PERIOD) + {6'b0, lfsr[3:0]};
      else if (state_q == COUNTING && enable && timer != 10'd0)
        timer <= timer - 10'd1;
    end
  end

  // Bomb slots: load from an ack, otherwise move, collide or exit on frame ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      alive <= '0;
      for (int i = 0; i < NUM_BOMBS; i++) begin
        slot_x[i] <= 10'(SCREEN_WIDTH - 1);
        slot_y[i] <= 10'(SCREEN_HEIGHT - 1);
      end
    end else begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        if (load_en && load_sel[i]) begin
          alive[i]  <= 1'b1;
          slot_x[i] <= dropX;
          slot_y[i] <= dropY;
        end else if (enable && alive[i]) begin
          if (ship_hit[i] || laser_hit[i] || bottom_exit[i]) begin
            alive[i]  <= 1'b0;
            slot_x[i] <= 10'(SCREEN_WIDTH - 1);
            slot_y[i] <= 10'(SCREEN_HEIGHT - 1);
          end else begin
            slot_y[i] <= slot_y[i] + 10'(STEP_MOTION);
          end
        end
      end
    end
  end

  // Registered status outputs: event pulses, live count and pixel colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      hitShip     <= 1'b0;
      killingBomb <= 1'b0;
      bombsAlive  <= '0;
      colorBomb   <= BACKGROUND;
    end else begin
      hitShip     <= enable && |(alive & ship_hit);
      killingBomb <= enable && |(alive & laser_hit & ~ship_hit);
      bombsAlive  <= count_live(alive);
      colorBomb   <= (|(alive & in_disc)) ? BOMB : BACKGROUND;
    end
  end

endmodule

// File: tb/tb_alien_bomb_dropper.sv
// tb_alien_bomb_dropper: directed opening sequence followed by randomized traffic,
// every cycle compared against a behavioural model of the bomb dropper.
module tb_alien_bomb_dropper;

  localparam int NB    = 4;
  localparam int RAD   = 3;
  localparam int STEP  = 2;
  localparam int FIRE  = 32;
  localparam int SW    = 640;
  localparam int SH    = 480;
  localparam int SHIPW = 60;
  localparam int SHIPH = 30;
  localparam int VOFF  = 10;

  logic       clk = 1'b0;
  logic       reset, enable, dropAck, dropNone;
  logic [9:0] dropX, dropY, gunPosition, xLaser, yLaser, hPos, vPos;
  logic       dropReq, hitShip, killingBomb;
  logic [2:0] bombsAlive, colorBomb;

  int checks   = 0;
  int failures = 0;

  int mAlive [NB];
  int mX [NB];
  int mY [NB];
  int mTimer, mLfsr, mReq, mHit, mKill, mCount, mColor;

  alien_bomb_dropper dut (
    .clk(clk), .reset(reset), .enable(enable), .dropAck(dropAck), .dropNone(dropNone),
    .dropX(dropX), .dropY(dropY), .gunPosition(gunPosition), .xLaser(xLaser),
    .yLaser(yLaser), .hPos(hPos), .vPos(vPos), .dropReq(dropReq), .hitShip(hitShip),
    .killingBomb(killingBomb), .bombsAlive(bombsAlive), .colorBomb(colorBomb)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the reference model by one clock using the inputs currently driven.
  task automatic modelStep();
    int color, cnt, free, hit, kill, ack, fb;
    if (reset) begin
      foreach (mAlive[i]) begin
        mAlive[i] = 0;
        mX[i] = SW - 1;
        mY[i] = SH - 1;
      end
      mTimer = FIRE; mLfsr = 'hACE1; mReq = 0;
      mHit = 0; mKill = 0; mCount = 0; mColor = 0;
    end else begin
      color = 0; cnt = 0; free = -1; hit = 0; kill = 0;
      foreach (mAlive[i]) begin
        if (mAlive[i] != 0) begin
          cnt++;
          if ((int'(hPos) - mX[i]) ** 2 + (int'(vPos) - mY[i]) ** 2 <= RAD * RAD) color = 5;
        end else if (free < 0) free = i;
      end
      ack = (mReq != 0 && dropAck) ? 1 : 0;
      if (ack != 0) begin
        mTimer = FIRE + (mLfsr & 15);
        mReq = 0;
      end else if (mReq == 0) begin
        if (mTimer == 0 && free >= 0) mReq = 1;
        else if (enable && mTimer > 0) mTimer = mTimer - 1;
      end
      if (enable) begin
        fb = ((mLfsr >> 15) ^ (mLfsr >> 13) ^ (mLfsr >> 12) ^ (mLfsr >> 10)) & 1;
        mLfsr = ((mLfsr << 1) | fb) & 'hFFFF;
        foreach (mAlive[i]) begin
          if (mAlive[i] != 0) begin
            if (iabs(mX[i] - int'(gunPosition)) <= SHIPW / 2 && mY[i] >= SH - VOFF - SHIPH) begin
              hit = 1; mAlive[i] = 0; mX[i] = SW - 1; mY[i] = SH - 1;
            end
`ifdef BOMB_LASER_COLLIDE_EN
            else if (iabs(mX[i] - int'(xLaser)) <= 2 * RAD && iabs(mY[i] - int'(yLaser)) <= 2 * RAD) begin
              kill = 1; mAlive[i] = 0; mX[i] = SW - 1; mY[i] = SH - 1;
            end
`endif
            else if (mY[i] + STEP >= SH) begin
              mAlive[i] = 0; mX[i] = SW - 1; mY[i] = SH - 1;
            end else mY[i] = mY[i] + STEP;
          end
        end
      end
      if (ack != 0 && !dropNone && free >= 0) begin
        mAlive[free] = 1; mX[free] = int'(dropX); mY[free] = int'(dropY);
      end
      mHit = hit; mKill = kill; mCount = cnt; mColor = color;
    end
  endtask

  // One clock: update the model, let the DUT clock, compare at the falling edge.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput("dropReq", dropReq, mReq);
    checkOutput("hitShip", hitShip, mHit);
    checkOutput("killingBomb", killingBomb, mKill);
    checkOutput("bombsAlive", bombsAlive, mCount);
    checkOutput("colorBomb", colorBomb, mColor);
  endtask

  initial begin
    int k, t;
    reset = 1'b1; enable = 1'b0; dropAck = 1'b0; dropNone = 1'b0;
    dropX = '0; dropY = '0; gunPosition = 10'd400; xLaser = 10'd0; yLaser = 10'd0;
    hPos = '0; vPos = '0;
    @(negedge clk);
    applyStimulus();
    dropAck = 1'b1;
    applyStimulus();
    dropAck = 1'b0;
    checkOutput("reset_dropReq", dropReq, 0);
    checkOutput("reset_bombsAlive", bombsAlive, 0);
    checkOutput("reset_colorBomb", colorBomb, 0);
    checkOutput("reset_hitShip", hitShip, 0);

    reset = 1'b0;
    for (int i = 0; i < FIRE; i++) begin
      enable = 1'b1; applyStimulus();
      enable = 1'b0; applyStimulus();
    end
    checkOutput("req_after_period", dropReq, 1);

    dropAck = 1'b1; dropNone = 1'b0; dropX = 10'd200; dropY = 10'd100;
    applyStimulus();
    dropAck = 1'b0;
    checkOutput("req_cleared_by_ack", dropReq, 0);
    applyStimulus();
    checkOutput("alive_after_ack", bombsAlive, 1);

    hPos = 10'd202; vPos = 10'd101; applyStimulus();
    checkOutput("disc_inside", colorBomb, 5);
    hPos = 10'd203; vPos = 10'd100; applyStimulus();
    checkOutput("disc_edge", colorBomb, 5);
    hPos = 10'd204; vPos = 10'd101; applyStimulus();
    checkOutput("disc_outside", colorBomb, 0);

    for (int n = 0; n < 20000; n++) begin
      reset   = ($urandom % 1000) == 0;
      enable  = ($urandom % 3) == 0;
      dropAck = (mReq != 0) ? (($urandom % 4) == 0) : (($urandom % 50) == 0);
      dropNone = ($urandom % 4) == 0;
      if (($urandom % 200) == 0) gunPosition = 10'($urandom_range(30, 610));
      t = int'(gunPosition) + int'($urandom_range(0, 80)) - 40;
      if (t < 0) t = 0;
      if (t > SW - 1) t = SW - 1;
      dropX = 10'(t);
      dropY = 10'($urandom_range(40, 470));
      k = int'($urandom % NB);
      t = mX[k] + int'($urandom_range(0, 8)) - 4;
      hPos = 10'((t < 0) ? 0 : t);
      t = mY[k] + int'($urandom_range(0, 8)) - 4;
      vPos = 10'((t < 0) ? 0 : t);
      k = int'($urandom % NB);
      t = mX[k] + int'($urandom_range(0, 16)) - 8;
      xLaser = 10'((t < 0) ? 0 : t);
      t = mY[k] + int'($urandom_range(0, 16)) - 8;
      yLaser = 10'((t < 0) ? 0 : t);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
